// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM encoding
// and the 50 MHz board timing constants.
package button_debouncer_pkg;

  typedef enum logic [2:0] {
    ST_RELEASED     = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEATING    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_fsm_e;

  // 50 MHz board clock: 20 ms debounce, 0.5 s repeat delay, 0.1 s repeat rate
  localparam int unsigned DEB_20MS_CYCLES      = 1000000;
  localparam int unsigned REP_DELAY_0P5S_CYCLES = 25000000;
  localparam int unsigned REP_RATE_0P1S_CYCLES  = 5000000;
  localparam int unsigned CNT_W_DEFAULT         = 25;

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: polarity normalise, 2-flop synchroniser, debounce /
// auto-repeat FSM with its counter and registered event pulses.
//
// state        | meaning
// RELEASED     | debounced level 0, waiting for the pin to go active
// PRESS_WAIT   | pin active, counting the debounce window before accepting
// HELD         | press accepted, counting the initial repeat delay
// REPEATING    | auto-repeat running, one pulse per repeat period
// RELEASE_WAIT | pin inactive while pressed, counting the release window
module button_debouncer_channel
  import button_debouncer_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_CYCLES,
  parameter int unsigned REPEAT_DELAY    = REP_DELAY_0P5S_CYCLES,
  parameter int unsigned REPEAT_RATE     = REP_RATE_0P1S_CYCLES,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_TC = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_norm;
  logic             w_sync;
  logic [1:0]       r_sync;
  btn_fsm_e         r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_btn_state, w_btn_state_nxt;
  logic             r_press, w_press_nxt;
  logic             r_release, w_release_nxt;
  logic             r_repeat, w_repeat_nxt;

  assign w_norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  assign w_sync = r_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync      <= 2'b00;
      r_state     <= ST_RELEASED;
      r_cnt       <= '0;
      r_btn_state <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], w_norm};
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_btn_state <= w_btn_state_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_repeat    <= w_repeat_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_ONE;
    w_btn_state_nxt = r_btn_state;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_repeat_nxt    = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        w_cnt_nxt = '0;
        if (w_sync) w_state_nxt = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!w_sync) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_TC) begin
          w_state_nxt     = ST_HELD;
          w_cnt_nxt       = '0;
          w_btn_state_nxt = 1'b1;
          w_press_nxt     = 1'b1;
        end
      end
      ST_HELD: begin
        if (!w_sync) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DLY_TC) begin
          w_state_nxt  = ST_REPEATING;
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b1;
        end
      end
      ST_REPEATING: begin
        if (!w_sync) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == RPT_TC) begin
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        // A short inactive glitch returns to HELD, so the repeat delay restarts
        if (w_sync) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_TC) begin
          w_state_nxt     = ST_RELEASED;
          w_cnt_nxt       = '0;
          w_btn_state_nxt = 1'b0;
          w_release_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_RELEASED;
        w_cnt_nxt       = '0;
        w_btn_state_nxt = 1'b0;
      end
    endcase
  end

  assign btn_state     = r_btn_state;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BUTTONS raw push buttons into clean levels and single-cycle
// press / release / auto-repeat events; any_held flags any button down.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_CYCLES,
  parameter int unsigned REPEAT_DELAY    = REP_DELAY_0P5S_CYCLES,
  parameter int unsigned REPEAT_RATE     = REP_RATE_0P1S_CYCLES,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_state,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] repeat_pulse,
  output logic                   any_held
);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_debouncer_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw[g]),
      .btn_state     (btn_state[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g]),
      .repeat_pulse  (repeat_pulse[g])
    );
  end

  assign any_held = |btn_state;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised + directed bench for button_debouncer, checked every cycle
// against a timestamp-based reference model of the debounce/repeat rules.
module tb_button_debouncer;

  localparam int NB = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_state, press_pulse, release_pulse, repeat_pulse;
  logic          any_held;

  button_debouncer #(
    .NUM_BUTTONS     (NB),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .CNT_W           (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .btn_state     (btn_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_held      (any_held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin history (two-edge delay), accepted level, length of
  // the current run of samples disagreeing with it, and next repeat time.
  bit      m_h1 [NB];
  bit      m_h2 [NB];
  bit      m_deb[NB];
  int      m_run[NB];
  longint  m_next_rep[NB];
  longint  now = 0;
  logic [NB-1:0] e_state, e_press, e_rel, e_rep;

  task automatic model_edge();
    now++;
    e_press = '0;
    e_rel   = '0;
    e_rep   = '0;
    for (int i = 0; i < NB; i++) begin
      bit s;
      if (reset) begin
        m_h1[i] = 0; m_h2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
        m_next_rep[i] = 0;
      end else begin
        s = m_h2[i];
        m_h2[i] = m_h1[i];
        m_h1[i] = ~btn_raw[i];
        if (s != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_deb[i] = s;
            m_run[i] = 0;
            if (s) begin
              e_press[i] = 1'b1;
              m_next_rep[i] = now + RD;
            end else begin
              e_rel[i] = 1'b1;
            end
          end
        end else begin
          if (m_deb[i] && m_run[i] > 0) begin
            m_next_rep[i] = now + RD;
          end else if (m_deb[i] && now == m_next_rep[i]) begin
            e_rep[i] = 1'b1;
            m_next_rep[i] = now + RR;
          end
          m_run[i] = 0;
        end
      end
      e_state[i] = m_deb[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("btn_state", 32'(btn_state), 32'(e_state));
    check("press_pulse", 32'(press_pulse), 32'(e_press));
    check("release_pulse", 32'(release_pulse), 32'(e_rel));
    check("repeat_pulse", 32'(repeat_pulse), 32'(e_rep));
    check("any_held", 32'(any_held), 32'(|e_state));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int hold_left[NB];

  initial begin
    reset   = 1'b1;
    btn_raw = 4'b1111;
    run(3);
    reset = 1'b0;
    run(3);

    // Single press / release on bit0
    btn_raw[0] = 1'b0; run(10);
    btn_raw[0] = 1'b1; run(10);

    // Bounces shorter than the debounce window on bit1
    for (int r = 0; r < 5; r++) begin
      btn_raw[1] = 1'b0; run(3);
      btn_raw[1] = 1'b1; run(3);
    end
    run(4);

    // Long hold on bit2 for auto-repeat
    btn_raw[2] = 1'b0; run(40);
    btn_raw[2] = 1'b1; run(10);

    // Release glitch on bit0 restarts the repeat delay
    btn_raw[0] = 1'b0; run(15);
    btn_raw[0] = 1'b1; run(2);
    btn_raw[0] = 1'b0; run(20);
    btn_raw[0] = 1'b1; run(10);

    // Simultaneous press/release on bits 0 and 3
    btn_raw = 4'b0110; run(12);
    btn_raw = 4'b1111; run(10);

    // Reset while bit2 is auto-repeating; still held after reset
    btn_raw[2] = 1'b0; run(25);
    reset = 1'b1; run(1);
    reset = 1'b0; run(12);
    btn_raw[2] = 1'b1; run(10);

    // Random phase: per-bit random hold lengths, mix of short and long
    for (int i = 0; i < NB; i++) hold_left[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        hold_left[i]--;
        if (hold_left[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold_left[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 30))
                                                      : int'($urandom_range(1, 6));
        end
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    btn_raw = 4'b1111;
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the seven-segment output path.
- Takes the board's raw, bouncy, active-low push buttons (S1–S4) and turns them into clean, synchronised levels plus single-cycle press, release and auto-repeat event pulses.
- Replaces the ad-hoc debounce/trap registers in top-level logic, so ALU/display stage control consumes clean events only.

Parameters:
- NUM_BUTTONS, 4, number of independent button channels.
- ACTIVE_LOW, 1, 1: raw pin low means pressed; 0: raw pin high means pressed.
- DEBOUNCE_CYCLES, 1000000, cycles a level must be stable before it is accepted (20 ms at 50 MHz); must be ≥2.
- REPEAT_DELAY, 25000000, held cycles after the press pulse before the first repeat pulse (0.5 s); must be ≥2.
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (0.1 s); must be ≥2.
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) − 1.

Ports:
- clk  input  1  system clock (50 MHz board clock or selected PLL output).
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  NUM_BUTTONS  raw asynchronous button pins.
- btn_state  output  NUM_BUTTONS  debounced level, 1 = pressed.
- press_pulse  output  NUM_BUTTONS  1-cycle pulse on accepted press.
- release_pulse  output  NUM_BUTTONS  1-cycle pulse on accepted release.
- repeat_pulse  output  NUM_BUTTONS  1-cycle pulse per auto-repeat tick while held.
- any_held  output  1  OR of btn_state (combinational from registered btn_state).

Behaviour:

Front end
- Each channel normalises the raw pin to active-high (invert when ACTIVE_LOW=1).
- It then passes through a 2-flop synchroniser, giving btn_sync.
- Reset loads both synchroniser flops with 0 (released).

Per-channel FSM (all transitions on posedge clk; cnt is the per-channel counter)
- RELEASED: btn_state=0.
  - btn_sync=1 → PRESS_WAIT, cnt=0.
- PRESS_WAIT: btn_sync=0 → RELEASED (bounce rejected, no pulse).
  - Otherwise, when cnt==DEBOUNCE_CYCLES−1 → HELD, cnt=0, btn_state←1, press_pulse←1 for one cycle.
  - Else cnt++.
- HELD: btn_sync=0 → RELEASE_WAIT, cnt=0.
  - Otherwise, when cnt==REPEAT_DELAY−1 → REPEATING, cnt=0, repeat_pulse←1 for one cycle.
  - Else cnt++.
- REPEATING: btn_sync=0 → RELEASE_WAIT, cnt=0.
  - Otherwise, when cnt==REPEAT_RATE−1 → cnt=0, repeat_pulse←1 for one cycle.
  - Else cnt++.
- RELEASE_WAIT: btn_state stays 1.
  - btn_sync=1 → HELD, cnt=0 (glitch rejected, repeat delay restarts, no pulse).
  - Otherwise, when cnt==DEBOUNCE_CYCLES−1 → RELEASED, btn_state←0, release_pulse←1 for one cycle.
  - Else cnt++.

Latency
- Let E0 be the first clock edge that samples the asserted pin level.
- btn_sync rises at E1; the FSM enters PRESS_WAIT at E2.
- btn_state and press_pulse rise at edge E0+DEBOUNCE_CYCLES+2.
- Release is symmetric: release_pulse at E0'+DEBOUNCE_CYCLES+2.
- First repeat_pulse comes REPEAT_DELAY cycles after press_pulse; later ones every REPEAT_RATE cycles.

Rules
- All outputs are registered except any_held.
- Pulses are exactly one cycle wide.
- press_pulse and release_pulse for the same channel never coincide.
- repeat_pulse never coincides with press_pulse.
- Counters never wrap: each is cleared on every state transition and on reaching its terminal count.
- Channels are fully independent; simultaneous presses produce simultaneous pulses on each bit.

Reset
- Every output = 0; all FSMs go to RELEASED; all counters = 0.
- Reset mid-press or mid-hold emits no release_pulse.
- After reset deasserts, a button still held down is treated as a new press and needs a full debounce.

Decomposition:
- Shared header (button_defs.vh) holds:
  - FSM state encodings (RELEASED, PRESS_WAIT, HELD, REPEATING, RELEASE_WAIT; 3-bit);
  - the 50 MHz cycle-count constants for 20 ms / 0.5 s / 0.1 s.
- One sub-module, button_channel: synchroniser, FSM, counter and the three pulse registers for a single button.
- button_debouncer instantiates NUM_BUTTONS copies in a generate loop and forms any_held.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW=1):
- Reset with btn_raw=4'b1111 → all outputs 0. Drive bit0 low at E0 → btn_state[0] and a 1-cycle press_pulse[0] at E0+6. Nothing on other bits.
- bit1 low for 3 cycles, then high, repeated 5 times → press_pulse[1] and btn_state[1] stay 0 throughout.
- bit2 held low for 30 cycles after press_pulse → repeat_pulse[2] at press+10, +13, +16, +19, … Each is 1 cycle wide, none coincides with press_pulse.
- bit0 pressed, then raised for 2 cycles, then low again → no release_pulse. The repeat delay restarts: next repeat_pulse comes 10 cycles after RELEASE_WAIT→HELD.
- bits 0 and 3 pressed on the same cycle, then released together → press_pulse=4'b1001 in one cycle, release_pulse=4'b1001 in one cycle. any_held is 1 exactly while btn_state≠0.
- Assert reset while bit2 is in REPEATING → next cycle all outputs 0, no release_pulse. With bit2 still low after reset, press_pulse[2] arrives DEBOUNCE_CYCLES+2 edges after the first post-reset sample.
